// File: rtl/div_pkg.sv
// Shared constants and helpers for the pipelined restoring divider.
package div_pkg;

  localparam int unsigned FLG_VALID  = 0;
  localparam int unsigned FLG_SIGN_Q = 1;
  localparam int unsigned FLG_SIGN_R = 2;
  localparam int unsigned FLG_DZ     = 3;
  localparam int unsigned FLG_OVF    = 4;
  localparam int unsigned FLG_W      = 5;

  function automatic int unsigned div_latency(input int unsigned w);
    return w + 2;
  endfunction

  // Most-negative two's-complement pattern for a w-bit word (w <= 64).
  function automatic logic [63:0] div_min_pattern(input int unsigned w);
    return 64'd1 << (w - 1);
  endfunction

endpackage

// File: rtl/div_restore_stage.sv
// One registered restoring-division step plus the travelling sideband.
module div_restore_stage
  import div_pkg::*;
#(
  parameter int unsigned W     = 8,
  parameter int unsigned TAG_W = 4,
  parameter int unsigned BIT   = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [W-1:0]     pr_in,
  input  logic [W-1:0]     nq_in,
  input  logic [W-1:0]     d_in,
  input  logic [FLG_W-1:0] flg_in,
  input  logic [TAG_W-1:0] tag_in,
  output logic [W-1:0]     pr_out,
  output logic [W-1:0]     nq_out,
  output logic [W-1:0]     d_out,
  output logic [FLG_W-1:0] flg_out,
  output logic [TAG_W-1:0] tag_out
);

  logic [W:0]       shifted;
  logic [W:0]       diff;
  logic             ge;
  logic [W-1:0]     pr_d, pr_q;
  logic [W-1:0]     nq_d, nq_q;
  logic [W-1:0]     d_d, d_q;
  logic [FLG_W-1:0] flg_d, flg_q;
  logic [TAG_W-1:0] tag_d, tag_q;

  // nq holds unconsumed dividend bits below BIT and finished quotient bits
  // above it; this step swaps dividend bit BIT for quotient bit BIT.
  always_comb begin
    shifted = {pr_in, nq_in[BIT]};
    diff    = shifted - {1'b0, d_in};
    ge      = ~diff[W];
    pr_d    = pr_q;
    nq_d    = nq_q;
    d_d     = d_q;
    flg_d   = flg_q;
    tag_d   = tag_q;
    if (en) begin
      pr_d      = ge ? diff[W-1:0] : shifted[W-1:0];
      nq_d      = nq_in;
      nq_d[BIT] = ge;
      d_d       = d_in;
      flg_d     = flg_in;
      tag_d     = tag_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pr_q  <= '0;
      nq_q  <= '0;
      d_q   <= '0;
      flg_q <= '0;
      tag_q <= '0;
    end else begin
      pr_q  <= pr_d;
      nq_q  <= nq_d;
      d_q   <= d_d;
      flg_q <= flg_d;
      tag_q <= tag_d;
    end
  end

  assign pr_out  = pr_q;
  assign nq_out  = nq_q;
  assign d_out   = d_q;
  assign flg_out = flg_q;
  assign tag_out = tag_q;

endmodule

// File: rtl/pipelined_signed_divider.sv
// Fully pipelined signed/unsigned restoring divider, one op per enabled cycle,
// fixed latency W+2, with tag pass-through and div-by-zero / overflow flags.
module pipelined_signed_divider
  import div_pkg::*;
#(
  parameter int unsigned W      = 8,
  parameter bit          SIGNED = 1'b1,
  parameter int unsigned TAG_W  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             in_valid,
  input  logic [W-1:0]     dividend,
  input  logic [W-1:0]     divisor,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  output logic [W-1:0]     quotient,
  output logic [W-1:0]     remainder,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_dz,
  output logic             out_ovf
);

  localparam logic [W-1:0] MIN = W'(div_min_pattern(W));

  logic             sgn_n, sgn_d;
  logic [W-1:0]     mag_n_d, mag_n_q;
  logic [W-1:0]     mag_d_d, mag_d_q;
  logic [FLG_W-1:0] flg0_d, flg0_q;
  logic [TAG_W-1:0] tag0_d, tag0_q;

  always_comb begin
    sgn_n   = SIGNED & dividend[W-1];
    sgn_d   = SIGNED & divisor[W-1];
    mag_n_d = mag_n_q;
    mag_d_d = mag_d_q;
    flg0_d  = flg0_q;
    tag0_d  = tag0_q;
    if (en) begin
      mag_n_d            = sgn_n ? -dividend : dividend;
      mag_d_d            = sgn_d ? -divisor : divisor;
      flg0_d[FLG_VALID]  = in_valid;
      flg0_d[FLG_SIGN_Q] = sgn_n ^ sgn_d;
      flg0_d[FLG_SIGN_R] = sgn_n;
      flg0_d[FLG_DZ]     = (divisor == '0);
      flg0_d[FLG_OVF]    = SIGNED && (dividend == MIN) && (divisor == '1);
      tag0_d             = in_tag;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mag_n_q <= '0;
      mag_d_q <= '0;
      flg0_q  <= '0;
      tag0_q  <= '0;
    end else begin
      mag_n_q <= mag_n_d;
      mag_d_q <= mag_d_d;
      flg0_q  <= flg0_d;
      tag0_q  <= tag0_d;
    end
  end

  logic [W-1:0]     pr_s  [0:W];
  logic [W-1:0]     nq_s  [0:W];
  logic [W-1:0]     d_s   [0:W];
  logic [FLG_W-1:0] flg_s [0:W];
  logic [TAG_W-1:0] tag_s [0:W];

  assign pr_s[0]  = '0;
  assign nq_s[0]  = mag_n_q;
  assign d_s[0]   = mag_d_q;
  assign flg_s[0] = flg0_q;
  assign tag_s[0] = tag0_q;

  for (genvar i = 1; i <= W; i++) begin : g_step
    div_restore_stage #(
      .W     (W),
      .TAG_W (TAG_W),
      .BIT   (W - i)
    ) u_stage (
      .clk     (clk),
      .rst_n   (rst_n),
      .en      (en),
      .pr_in   (pr_s[i-1]),
      .nq_in   (nq_s[i-1]),
      .d_in    (d_s[i-1]),
      .flg_in  (flg_s[i-1]),
      .tag_in  (tag_s[i-1]),
      .pr_out  (pr_s[i]),
      .nq_out  (nq_s[i]),
      .d_out   (d_s[i]),
      .flg_out (flg_s[i]),
      .tag_out (tag_s[i])
    );
  end

  logic             out_valid_d, out_valid_q;
  logic [W-1:0]     quotient_d, quotient_q;
  logic [W-1:0]     remainder_d, remainder_q;
  logic [TAG_W-1:0] out_tag_d, out_tag_q;
  logic             out_dz_d, out_dz_q;
  logic             out_ovf_d, out_ovf_q;

  // A zero divisor magnitude yields an all-ones raw quotient and |dividend|
  // as remainder; only the quotient needs forcing, the sign fix restores r.
  always_comb begin
    out_valid_d = out_valid_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    out_tag_d   = out_tag_q;
    out_dz_d    = out_dz_q;
    out_ovf_d   = out_ovf_q;
    if (en) begin
      out_valid_d = flg_s[W][FLG_VALID];
      quotient_d  = (d_s[W] == '0) ? '1 :
                    (flg_s[W][FLG_SIGN_Q] ? -nq_s[W] : nq_s[W]);
      remainder_d = flg_s[W][FLG_SIGN_R] ? -pr_s[W] : pr_s[W];
      out_tag_d   = tag_s[W];
      out_dz_d    = flg_s[W][FLG_DZ];
      out_ovf_d   = flg_s[W][FLG_OVF];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      out_tag_q   <= '0;
      out_dz_q    <= 1'b0;
      out_ovf_q   <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      out_tag_q   <= out_tag_d;
      out_dz_q    <= out_dz_d;
      out_ovf_q   <= out_ovf_d;
    end
  end

  assign out_valid = out_valid_q;
  assign quotient  = quotient_q;
  assign remainder = remainder_q;
  assign out_tag   = out_tag_q;
  assign out_dz    = out_dz_q;
  assign out_ovf   = out_ovf_q;

endmodule
